// File: rtl/fetch_unpack_pkg.sv
// Shared fetch geometry for the fetch-unpack slice.
package fetch_unpack_pkg;

   localparam int unsigned NUM_FETCH    = 2;
   localparam int unsigned ICACHE_ALIGN = 4 * NUM_FETCH;
   localparam int unsigned DEPTH_WARP   = 3;
   localparam int unsigned NUM_WARP     = 2 ** DEPTH_WARP;
   localparam int unsigned INST_W       = 32;

   // Index width that stays legal for a single-lane configuration.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fetch_lane_pick.sv
// Picks the lowest pending lane: one-hot select, binary index and a
// flag saying it is the only pending lane.
module fetch_lane_pick
   import fetch_unpack_pkg::*;
#(
   parameter int unsigned N     = NUM_FETCH,
   parameter int unsigned IDX_W = idx_width(N)
) (
   input  logic [N-1:0]     i_rem,
   output logic [N-1:0]     o_onehot,
   output logic [IDX_W-1:0] o_idx,
   output logic             o_single
);

   logic w_found;

   always_comb begin
      o_onehot = '0;
      o_idx    = '0;
      w_found  = 1'b0;
      for (int i = 0; i < int'(N); i++) begin
         if (i_rem[i] && !w_found) begin
            o_onehot[i] = 1'b1;
            o_idx       = IDX_W'(i);
            w_found     = 1'b1;
         end
      end
   end

   assign o_single = (i_rem != '0) && ((i_rem & ~o_onehot) == '0);

endmodule

// File: rtl/fetch_unpack.sv
// Holds one aligned fetch packet and streams its valid lanes, lowest first,
// one instruction per cycle; a flush of the held warp drops what is left.
module fetch_unpack #(
   parameter int unsigned NUM_FETCH  = fetch_unpack_pkg::NUM_FETCH,
   parameter int unsigned DEPTH_WARP = fetch_unpack_pkg::DEPTH_WARP
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [DEPTH_WARP-1:0]   in_wid,
   input  logic [31:0]             in_pc_aligned,
   input  logic [NUM_FETCH-1:0]    in_mask,
   input  logic [32*NUM_FETCH-1:0] in_data,
   input  logic                    flush_valid,
   input  logic [DEPTH_WARP-1:0]   flush_wid,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_inst,
   output logic [31:0]             out_pc,
   output logic [DEPTH_WARP-1:0]   out_wid,
   output logic                    out_last
);

   import fetch_unpack_pkg::*;

   localparam int unsigned IDX_W = idx_width(NUM_FETCH);

   logic [DEPTH_WARP-1:0]   r_wid;
   logic [31:0]             r_pc;
   logic [32*NUM_FETCH-1:0] r_data;
   logic [NUM_FETCH-1:0]    r_rem;

   logic [NUM_FETCH-1:0] w_rem_next;
   logic [NUM_FETCH-1:0] w_onehot;
   logic [IDX_W-1:0]     w_idx;
   logic                 w_single;
   logic                 w_busy;
   logic                 w_kill;
   logic                 w_fire_in;
   logic                 w_fire_out;
   logic                 w_drop_in;
   logic [31:0]          w_inst;

   fetch_lane_pick #(
      .N     (NUM_FETCH),
      .IDX_W (IDX_W)
   ) u_pick (
      .i_rem    (r_rem),
      .o_onehot (w_onehot),
      .o_idx    (w_idx),
      .o_single (w_single)
   );

   assign w_busy     = |r_rem;
   assign w_kill     = flush_valid && w_busy && (flush_wid == r_wid);
   assign out_valid  = w_busy && !w_kill;
   assign w_fire_out = out_valid && out_ready;
   // Accept while draining the final lane so packets stream without a bubble.
   assign in_ready   = !w_busy || (w_single && out_ready && !w_kill) || w_kill;
   assign w_fire_in  = in_valid && in_ready;
   assign w_drop_in  = flush_valid && (flush_wid == in_wid);

   always_comb begin
      w_inst = '0;
      for (int i = 0; i < int'(NUM_FETCH); i++) begin
         if (w_onehot[i]) w_inst = w_inst | r_data[32*i +: 32];
      end
   end

   assign out_inst = w_inst;
   assign out_pc   = r_pc + (32'(w_idx) << 2);
   assign out_wid  = r_wid;
   assign out_last = w_single;

   always_comb begin
      w_rem_next = r_rem;
      if (w_fire_in) begin
         w_rem_next = w_drop_in ? '0 : in_mask;
      end else if (w_kill) begin
         w_rem_next = '0;
      end else if (w_fire_out) begin
         w_rem_next = r_rem & ~w_onehot;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rem  <= '0;
         r_wid  <= '0;
         r_pc   <= '0;
         r_data <= '0;
      end else begin
         r_rem <= w_rem_next;
         if (w_fire_in) begin
            r_wid  <= in_wid;
            r_pc   <= in_pc_aligned;
            r_data <= in_data;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unpack.sv
// Self-checking bench for fetch_unpack: directed scenarios plus a randomized
// run scored against a lane-queue reference model.
module tb_fetch_unpack;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [2:0]  in_wid = '0;
   logic [31:0] in_pc = '0;
   logic [1:0]  in_mask = '0;
   logic [63:0] in_data = '0;
   logic        flush_valid = 1'b0;
   logic [2:0]  flush_wid = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic [2:0]  out_wid;
   logic        out_last;

   logic         in_valid4 = 1'b0;
   logic         in_ready4;
   logic [2:0]   in_wid4 = '0;
   logic [31:0]  in_pc4 = '0;
   logic [3:0]   in_mask4 = '0;
   logic [127:0] in_data4 = '0;
   logic         out_valid4;
   logic [31:0]  out_inst4;
   logic [31:0]  out_pc4;
   logic [2:0]   out_wid4;
   logic         out_last4;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] inst;
      logic [31:0] pc;
      logic [2:0]  wid;
   } lane_t;

   always #5 clk = ~clk;

   fetch_unpack #(.NUM_FETCH(2), .DEPTH_WARP(3)) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_wid        (in_wid),
      .in_pc_aligned (in_pc),
      .in_mask       (in_mask),
      .in_data       (in_data),
      .flush_valid   (flush_valid),
      .flush_wid     (flush_wid),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_inst      (out_inst),
      .out_pc        (out_pc),
      .out_wid       (out_wid),
      .out_last      (out_last)
   );

   fetch_unpack #(.NUM_FETCH(4), .DEPTH_WARP(3)) dut4 (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid4),
      .in_ready      (in_ready4),
      .in_wid        (in_wid4),
      .in_pc_aligned (in_pc4),
      .in_mask       (in_mask4),
      .in_data       (in_data4),
      .flush_valid   (flush_valid),
      .flush_wid     (flush_wid),
      .out_valid     (out_valid4),
      .out_ready     (out_ready),
      .out_inst      (out_inst4),
      .out_pc        (out_pc4),
      .out_wid       (out_wid4),
      .out_last      (out_last4)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
      checks++; if (out_inst !== 32'h0 || out_pc !== 32'h0) begin errors++; $display("FAIL reset_inst_pc got %h/%h exp 0/0", out_inst, out_pc); end
      checks++; if (out_wid !== 3'd0 || out_last !== 1'b0) begin errors++; $display("FAIL reset_wid_last got %0d/%b exp 0/0", out_wid, out_last); end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_unaligned();
      in_valid = 1'b1; in_wid = 3'd5; in_pc = 32'd24; in_mask = 2'b10;
      in_data = {32'hDEAD_0001, 32'hBEEF_0000};
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL unaligned_valid got %b exp 1", out_valid); end
      checks++; if (out_inst !== 32'hDEAD_0001) begin errors++; $display("FAIL unaligned_inst got %h exp DEAD0001", out_inst); end
      checks++; if (out_pc !== 32'd28) begin errors++; $display("FAIL unaligned_pc got %0d exp 28", out_pc); end
      checks++; if (out_wid !== 3'd5 || out_last !== 1'b1) begin errors++; $display("FAIL unaligned_wid_last got %0d/%b exp 5/1", out_wid, out_last); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL unaligned_in_ready got %b exp 1", in_ready); end
      tick();
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL unaligned_done got %b exp 0", out_valid); end
      tick();
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_pc [4];
      exp_pc[0] = 32'h100; exp_pc[1] = 32'h104; exp_pc[2] = 32'h200; exp_pc[3] = 32'h204;
      in_valid = 1'b1; in_wid = 3'd1; in_mask = 2'b11; in_pc = 32'h100;
      in_data = {32'h104 ^ 32'hA5A5_0000, 32'h100 ^ 32'hA5A5_0000};
      tick();
      in_pc = 32'h200;
      in_data = {32'h204 ^ 32'hA5A5_0000, 32'h200 ^ 32'hA5A5_0000};
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b1 || out_pc !== exp_pc[i]) begin errors++; $display("FAIL b2b_pc[%0d] got %b/%h exp 1/%h", i, out_valid, out_pc, exp_pc[i]); end
         checks++; if (out_inst !== (exp_pc[i] ^ 32'hA5A5_0000)) begin errors++; $display("FAIL b2b_inst[%0d] got %h exp %h", i, out_inst, exp_pc[i] ^ 32'hA5A5_0000); end
         checks++; if (out_last !== (i % 2 == 1)) begin errors++; $display("FAIL b2b_last[%0d] got %b exp %b", i, out_last, (i % 2 == 1)); end
         tick();
         if (i == 1) in_valid = 1'b0;
      end
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_done got %b exp 0", out_valid); end
      tick();
   endtask

   task automatic test_backpressure();
      out_ready = 1'b0;
      in_valid = 1'b1; in_wid = 3'd4; in_mask = 2'b11; in_pc = 32'h40;
      in_data = {32'h1111_0044, 32'h1111_0040};
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++; if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_inst !== 32'h1111_0040) begin errors++; $display("FAIL bp_hold[%0d] got %b/%h/%h exp 1/40/11110040", i, out_valid, out_pc, out_inst); end
         checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d] got %b exp 0", i, in_ready); end
         tick();
      end
      out_ready = 1'b1;
      @(negedge clk);
      checks++; if (out_pc !== 32'h40 || out_last !== 1'b0) begin errors++; $display("FAIL bp_rel0 got %h/%b exp 40/0", out_pc, out_last); end
      tick();
      @(negedge clk);
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'h44 || out_last !== 1'b1) begin errors++; $display("FAIL bp_rel1 got %b/%h/%b exp 1/44/1", out_valid, out_pc, out_last); end
      tick();
   endtask

   task automatic test_flush();
      for (int rep = 0; rep < 2; rep++) begin
         in_valid = 1'b1; in_wid = 3'd2; in_mask = 2'b11; in_pc = 32'h80;
         in_data = {32'h2222_0084, 32'h2222_0080};
         tick();
         in_valid = 1'b0;
         @(negedge clk);
         checks++; if (out_pc !== 32'h80 || out_valid !== 1'b1) begin errors++; $display("FAIL flush_first[%0d] got %b/%h exp 1/80", rep, out_valid, out_pc); end
         tick();
         flush_valid = 1'b1;
         flush_wid = (rep == 0) ? 3'd2 : 3'd3;
         @(negedge clk);
         if (rep == 0) begin
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_kill got %b exp 0", out_valid); end
         end else begin
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'h84) begin errors++; $display("FAIL flush_other got %b/%h exp 1/84", out_valid, out_pc); end
         end
         checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready[%0d] got %b exp 1", rep, in_ready); end
         tick();
         flush_valid = 1'b0;
         @(negedge clk);
         checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_after[%0d] got %b exp 0", rep, out_valid); end
         tick();
      end
      // Packet accepted in the same cycle its warp is flushed is dropped.
      in_valid = 1'b1; in_wid = 3'd6; in_mask = 2'b11; in_pc = 32'h300;
      flush_valid = 1'b1; flush_wid = 3'd6;
      tick();
      in_valid = 1'b0; flush_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flush_on_accept got %b/%b exp 0/1", out_valid, in_ready); end
      tick();
   endtask

   task automatic test_edge_masks();
      in_valid = 1'b1; in_wid = 3'd0; in_mask = 2'b00; in_pc = 32'h500;
      tick();
      in_valid = 1'b0;
      @(negedge clk);
      checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL mask_zero got %b/%b exp 0/1", out_valid, in_ready); end
      tick();
      in_valid4 = 1'b1; in_wid4 = 3'd7; in_mask4 = 4'b1010; in_pc4 = 32'hFFFF_FFF0;
      in_data4 = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
      tick();
      in_valid4 = 1'b0;
      @(negedge clk);
      checks++; if (out_valid4 !== 1'b1 || out_pc4 !== 32'hFFFF_FFF4 || out_inst4 !== 32'hC1 || out_last4 !== 1'b0) begin errors++; $display("FAIL wrap_lane1 got %b/%h/%h/%b exp 1/FFFFFFF4/C1/0", out_valid4, out_pc4, out_inst4, out_last4); end
      tick();
      @(negedge clk);
      checks++; if (out_valid4 !== 1'b1 || out_pc4 !== 32'hFFFF_FFFC || out_inst4 !== 32'hC3 || out_last4 !== 1'b1) begin errors++; $display("FAIL wrap_lane3 got %b/%h/%h/%b exp 1/FFFFFFFC/C3/1", out_valid4, out_pc4, out_inst4, out_last4); end
      checks++; if (out_wid4 !== 3'd7) begin errors++; $display("FAIL wrap_wid got %0d exp 7", out_wid4); end
      tick();
      @(negedge clk);
      checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL wrap_done got %b exp 0", out_valid4); end
      tick();
   endtask

   task automatic test_reset_mid();
      in_valid4 = 1'b1; in_wid4 = 3'd1; in_mask4 = 4'b1111; in_pc4 = 32'h1000;
      tick();
      in_valid4 = 1'b0;
      @(negedge clk);
      checks++; if (out_valid4 !== 1'b1 || out_pc4 !== 32'h1000) begin errors++; $display("FAIL rstmid_first got %b/%h exp 1/1000", out_valid4, out_pc4); end
      tick();
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++; if (out_valid4 !== 1'b0) begin errors++; $display("FAIL rstmid_async got %b exp 0", out_valid4); end
      tick();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         checks++; if (out_valid4 !== 1'b0 || in_ready4 !== 1'b1) begin errors++; $display("FAIL rstmid_stale[%0d] got %b/%b exp 0/1", i, out_valid4, in_ready4); end
         tick();
      end
   endtask

   task automatic test_random();
      lane_t q[$];
      lane_t ln;
      logic  busy, kill, exp_valid, exp_ready;
      q.delete();
      for (int cyc = 0; cyc < 2000; cyc++) begin
         in_valid    = ($urandom_range(0, 1) == 1);
         in_wid      = 3'($urandom_range(0, 3));
         in_pc       = $urandom & 32'hFFFF_FFF8;
         in_mask     = 2'($urandom_range(0, 3));
         in_data     = {$urandom, $urandom};
         flush_valid = ($urandom_range(0, 7) == 0);
         flush_wid   = 3'($urandom_range(0, 3));
         out_ready   = ($urandom_range(0, 3) != 0);
         @(negedge clk);
         busy      = (q.size() != 0);
         kill      = flush_valid && busy && (flush_wid == q[0].wid);
         exp_valid = busy && !kill;
         exp_ready = !busy || kill || (q.size() == 1 && out_ready);
         checks++; if (out_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid@%0d got %b exp %b", cyc, out_valid, exp_valid); end
         checks++; if (in_ready !== exp_ready) begin errors++; $display("FAIL rnd_in_ready@%0d got %b exp %b", cyc, in_ready, exp_ready); end
         if (exp_valid) begin
            checks++;
            if (out_inst !== q[0].inst || out_pc !== q[0].pc || out_wid !== q[0].wid
                || out_last !== (q.size() == 1)) begin
               errors++;
               $display("FAIL rnd_lane@%0d got %h/%h/%0d/%b exp %h/%h/%0d/%b", cyc, out_inst, out_pc,
                        out_wid, out_last, q[0].inst, q[0].pc, q[0].wid, (q.size() == 1));
            end
         end
         if (kill) q.delete();
         else if (exp_valid && out_ready) void'(q.pop_front());
         if (in_valid && exp_ready) begin
            q.delete();
            if (!(flush_valid && flush_wid == in_wid)) begin
               for (int i = 0; i < 2; i++) begin
                  if (in_mask[i]) begin
                     ln.inst = in_data[32*i +: 32];
                     ln.pc   = in_pc + 32'(4 * i);
                     ln.wid  = in_wid;
                     q.push_back(ln);
                  end
               end
            end
         end
         tick();
      end
      in_valid = 1'b0; flush_valid = 1'b0; out_ready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_unaligned();
      test_back_to_back();
      test_backpressure();
      test_flush();
      test_edge_masks();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
